// File: rtl/darth_pkg.sv
// Shared definitions for the invaders game: screen geometry, coordinate
// width and the shot controller FSM state type.
package darth_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {
        READY = 1'b0,
        COOL  = 1'b1
    } shot_state_e;

endpackage

// File: rtl/shot_slot.sv
// One laser shot slot: holds x, y and a live flag.
// A load takes priority over everything. This is safe because the top only
// loads a slot that was free at the start of the cycle. A load also
// suppresses the step in the same cycle, so a freshly launched shot is not
// moved. On a live slot, a kill beats a step. A step that would take y
// below zero retires the shot instead of wrapping.
module shot_slot
    import darth_pkg::*;
#(
    parameter int SHOT_STEP = 4
) (
    input  logic               clk_shot,
    input  logic               d_reset_n,
    input  logic               load_i,
    input  logic [COORD_W-1:0] load_x_i,
    input  logic [COORD_W-1:0] load_y_i,
    input  logic               step_i,
    input  logic               kill_i,
    output logic               active_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o
);

    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(SHOT_STEP);

    logic               active_q, active_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    // Next-state for the slot: load, then kill, then upward motion.
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        if (load_i) begin
            active_d = 1'b1;
            x_d      = load_x_i;
            y_d      = load_y_i;
        end else if (active_q) begin
            if (kill_i) begin
                active_d = 1'b0;
            end else if (step_i) begin
                if (y_q < STEP_C) begin
                    active_d = 1'b0;
                end else begin
                    y_d = y_q - STEP_C;
                end
            end
        end
    end

    // Slot registers; x and y keep their last values when the slot dies.
    always_ff @(posedge clk_shot or negedge d_reset_n) begin
        if (!d_reset_n) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;

endmodule

// File: rtl/shot_controller.sv
// Player laser shot scheduler.
// Turns fire presses into shots launched from ship_x at SHIP_Y. Each new
// shot takes the lowest free slot. A cooldown FSM (READY/COOL) rate-limits
// launches. Live shots move up by SHOT_STEP on every frame tick.
// Optional build macro SHOT_AUTOFIRE_EN: a held fire button also requests a
// shot on the first cycle after the cooldown ends, so it keeps repeating.
module shot_controller
    import darth_pkg::*;
#(
    parameter int NUM_SHOTS      = 4,
    parameter int SHIP_Y         = 440,
    parameter int SHOT_STEP      = 4,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic                         clk_shot,
    input  logic                         d_reset_n,
    input  logic                         tick,
    input  logic                         d_fire,
    input  logic [COORD_W-1:0]           ship_x,
    input  logic                         hit_valid,
    input  logic [2:0]                   hit_id,
    output logic                         fire_ack,
    output logic [NUM_SHOTS-1:0]         shot_active,
    output logic [COORD_W*NUM_SHOTS-1:0] shot_x,
    output logic [COORD_W*NUM_SHOTS-1:0] shot_y
);

    localparam int                 CNT_W    = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(COOLDOWN_TICKS);
    localparam logic [COORD_W-1:0] LAUNCH_Y = COORD_W'(SHIP_Y);

    shot_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fire_q;
    logic                 fire_req;
    logic                 free_found;
    logic [NUM_SHOTS-1:0] free_sel;
    logic [NUM_SHOTS-1:0] load_vec;
    logic [NUM_SHOTS-1:0] kill_vec;
`ifdef SHOT_AUTOFIRE_EN
    logic                 cool_done_q, cool_done_d;
`endif

    // Fire request: a rising edge of the button. While reset is asserted it
    // is forced low, so no ack can leak out.
    always_comb begin
        fire_req = d_reset_n & d_fire & ~fire_q;
`ifdef SHOT_AUTOFIRE_EN
        fire_req = fire_req | (d_reset_n & d_fire & cool_done_q);
`endif
    end

    // Lowest-index free slot, one-hot. This uses only the registered active
    // flags, so a slot freed this cycle is not handed out until the next one.
    always_comb begin
        free_found = 1'b0;
        free_sel   = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!shot_active[i] && !free_found) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    // Hit decode. An out-of-range hit_id matches no slot and is dropped.
    always_comb begin
        kill_vec = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            kill_vec[i] = hit_valid && (hit_id == 3'(i));
        end
    end

    // Cooldown FSM: allocation and ack in READY, tick countdown in COOL.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fire_ack = 1'b0;
        load_vec = '0;
`ifdef SHOT_AUTOFIRE_EN
        cool_done_d = 1'b0;
`endif
        case (state_q)
            READY: begin
                if (fire_req && free_found) begin
                    fire_ack = 1'b1;
                    load_vec = free_sel;
                    cnt_d    = CNT_LOAD;
                    state_d  = COOL;
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = READY;
`ifdef SHOT_AUTOFIRE_EN
                    cool_done_d = 1'b1;
`endif
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = READY;
`ifdef SHOT_AUTOFIRE_EN
                        cool_done_d = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // Control registers: FSM state, cooldown counter and fire edge register.
    always_ff @(posedge clk_shot or negedge d_reset_n) begin
        if (!d_reset_n) begin
            state_q     <= READY;
            cnt_q       <= '0;
            fire_q      <= 1'b0;
`ifdef SHOT_AUTOFIRE_EN
            cool_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fire_q      <= d_fire;
`ifdef SHOT_AUTOFIRE_EN
            cool_done_q <= cool_done_d;
`endif
        end
    end

    for (genvar g = 0; g < NUM_SHOTS; g++) begin : g_slot
        shot_slot #(
            .SHOT_STEP(SHOT_STEP)
        ) u_slot (
            .clk_shot (clk_shot),
            .d_reset_n(d_reset_n),
            .load_i   (load_vec[g]),
            .load_x_i (ship_x),
            .load_y_i (LAUNCH_Y),
            .step_i   (tick),
            .kill_i   (kill_vec[g]),
            .active_o (shot_active[g]),
            .x_o      (shot_x[COORD_W*g +: COORD_W]),
            .y_o      (shot_y[COORD_W*g +: COORD_W])
        );
    end

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller with default parameters
// (4 slots, launch y 440, step 4, cooldown 8 ticks).
module tb_shot_controller;

    logic        clk_shot = 1'b0;
    logic        d_reset_n;
    logic        tick;
    logic        d_fire;
    logic [9:0]  ship_x;
    logic        hit_valid;
    logic [2:0]  hit_id;
    logic        fire_ack;
    logic [3:0]  shot_active;
    logic [39:0] shot_x;
    logic [39:0] shot_y;

    int checks = 0;
    int errors = 0;
    int acks;
    int exp_acks;
    logic [3:0] exp_held_active;

    always #5 clk_shot = ~clk_shot;

    shot_controller dut (
        .clk_shot   (clk_shot),
        .d_reset_n  (d_reset_n),
        .tick       (tick),
        .d_fire     (d_fire),
        .ship_x     (ship_x),
        .hit_valid  (hit_valid),
        .hit_id     (hit_id),
        .fire_ack   (fire_ack),
        .shot_active(shot_active),
        .shot_x     (shot_x),
        .shot_y     (shot_y)
    );

    function automatic logic [9:0] sx(input int i);
        return shot_x[10*i +: 10];
    endfunction

    function automatic logic [9:0] sy(input int i);
        return shot_y[10*i +: 10];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_shot);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    // One button press: check the combinational ack, then release the button.
    task automatic fire(input string tag, input logic exp_ack, input logic with_tick);
        d_fire = 1'b1;
        tick   = with_tick;
        #1;
        chk(tag, fire_ack, exp_ack);
        cyc();
        d_fire = 1'b0;
        tick   = 1'b0;
        cyc();
    endtask

    initial begin
        d_reset_n = 1'b0;
        tick      = 1'b0;
        d_fire    = 1'b0;
        ship_x    = '0;
        hit_valid = 1'b0;
        hit_id    = '0;
        cyc();
        cyc();

        // Button activity during reset produces nothing
        for (int i = 0; i < 4; i++) begin
            d_fire = ~d_fire;
            #1;
            chk("rst_ack", fire_ack, 1'b0);
            cyc();
            chk("rst_active", shot_active, 4'b0000);
        end
        d_reset_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_active", shot_active, 4'b0000);
        chk("post_rst_x", shot_x, 40'd0);
        chk("post_rst_y", shot_y, 40'd0);
        chk("post_rst_ack", fire_ack, 1'b0);

        // First launch and motion
        ship_x = 10'd320;
        fire("t2_ack", 1'b1, 1'b0);
        chk("t2_active", shot_active, 4'b0001);
        chk("t2_x0", sx(0), 10'd320);
        chk("t2_y0", sy(0), 10'd440);
        ticks(3);
        chk("t2_y0_3ticks", sy(0), 10'd428);

        // Fire during cooldown is ignored; after 8 ticks it is accepted
        fire("t6_early", 1'b0, 1'b0);
        chk("t6_early_active", shot_active, 4'b0001);
        ticks(5);
        chk("t6_y0", sy(0), 10'd408);
        ship_x = 10'd100;
        fire("t6_accept", 1'b1, 1'b0);
        chk("t6_active", shot_active, 4'b0011);
        chk("t6_x1", sx(1), 10'd100);
        chk("t6_y1", sy(1), 10'd440);

        // Fill the pool; the fifth press finds no slot
        ticks(8);
        ship_x = 10'd200;
        fire("t3_s2", 1'b1, 1'b0);
        chk("t3_s2_active", shot_active, 4'b0111);
        chk("t3_x2", sx(2), 10'd200);
        ticks(8);
        ship_x = 10'd300;
        fire("t3_s3", 1'b1, 1'b0);
        chk("t3_full_active", shot_active, 4'b1111);
        chk("t3_x3", sx(3), 10'd300);
        chk("t3_y3", sy(3), 10'd440);
        ticks(8);
        chk("t3_y0", sy(0), 10'd312);
        chk("t3_y1", sy(1), 10'd344);
        chk("t3_y2", sy(2), 10'd376);
        chk("t3_y3_moved", sy(3), 10'd408);
        ship_x = 10'd400;
        fire("t3_no_slot", 1'b0, 1'b0);
        chk("t3_no_slot_active", shot_active, 4'b1111);
        chk("t3_x3_kept", sx(3), 10'd300);

        // Hit and tick together on slot 1
        hit_valid = 1'b1;
        hit_id    = 3'd1;
        tick      = 1'b1;
        cyc();
        hit_valid = 1'b0;
        tick      = 1'b0;
        chk("t5_active", shot_active, 4'b1101);
        chk("t5_y0", sy(0), 10'd308);
        chk("t5_y1_kept", sy(1), 10'd344);
        chk("t5_y2", sy(2), 10'd372);
        chk("t5_y3", sy(3), 10'd404);
        // Out-of-range hit id
        hit_valid = 1'b1;
        hit_id    = 3'd6;
        cyc();
        hit_valid = 1'b0;
        chk("t5_bad_id_active", shot_active, 4'b1101);
        chk("t5_bad_id_y0", sy(0), 10'd308);

        // Leave only slot 0, run it to the top edge
        hit_valid = 1'b1;
        hit_id    = 3'd2;
        cyc();
        hit_id    = 3'd3;
        cyc();
        hit_valid = 1'b0;
        chk("t4_one_left", shot_active, 4'b0001);
        ticks(77);
        chk("t4_at_zero_active", shot_active, 4'b0001);
        chk("t4_at_zero_y", sy(0), 10'd0);
        ticks(1);
        chk("t4_gone", shot_active, 4'b0000);
        chk("t4_y_kept", sy(0), 10'd0);

        // Reuse slot 0; a tick in the launch cycle does not move the new shot
        ship_x = 10'd555;
        fire("t4_reuse", 1'b1, 1'b1);
        chk("t4_reuse_active", shot_active, 4'b0001);
        chk("t4_reuse_x", sx(0), 10'd555);
        chk("t4_reuse_y", sy(0), 10'd440);

        // A slot freed this cycle is not reused this cycle
        ticks(8);
        chk("sim_y0", sy(0), 10'd408);
        ship_x    = 10'd77;
        d_fire    = 1'b1;
        hit_valid = 1'b1;
        hit_id    = 3'd0;
        #1;
        chk("sim_ack", fire_ack, 1'b1);
        cyc();
        d_fire    = 1'b0;
        hit_valid = 1'b0;
        cyc();
        chk("sim_active", shot_active, 4'b0010);
        chk("sim_x1", sx(1), 10'd77);
        chk("sim_y1", sy(1), 10'd440);

        // Reset mid-flight clears everything immediately
        #2;
        d_reset_n = 1'b0;
        #1;
        chk("midrst_active", shot_active, 4'b0000);
        chk("midrst_x", shot_x, 40'd0);
        chk("midrst_y", shot_y, 40'd0);
        cyc();
        d_reset_n = 1'b1;
        cyc();

        // Held button for 40 ticks
`ifdef SHOT_AUTOFIRE_EN
        exp_acks        = 4;
        exp_held_active = 4'b1111;
`else
        exp_acks        = 1;
        exp_held_active = 4'b0001;
`endif
        acks   = 0;
        d_fire = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick = 1'b1;
            #1;
            if (fire_ack) acks++;
            cyc();
            tick = 1'b0;
            #1;
            if (fire_ack) acks++;
            cyc();
        end
        d_fire = 1'b0;
        chk("held_acks", acks, exp_acks);
        chk("held_active", shot_active, exp_held_active);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
